// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_pkg
// Purpose  : Shared types and helpers for the decode hazard unit. It holds the
//            scoreboard entry layout, the bubble constant, the regfile
//            forwarding code and the readiness / liveness helpers.
// Contents : hz_entry_t, HZ_BUBBLE, FWD_REGFILE, fwd_ready(), hz_live()
// Revision : 1.0 - initial release
// ============================================================================
package hazard_unit_pkg;

  // Scoreboard rd field width. The top zero-extends register addresses into
  // this field, so REG_ADDR_W may be at most HZ_RD_W.
  localparam int HZ_RD_W = 8;

  // Forwarding select value meaning "read the register file".
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic               wr_en;
    logic               is_load;
    logic               is_mc;
    logic [HZ_RD_W-1:0] rd;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '0;

  // A stage's output carries a usable result: ALU results are available from
  // stage 1 onward, load data only from load_ready_stage onward.
  function automatic logic fwd_ready(input int stage_idx, input logic is_load,
                                     input int load_ready_stage);
    if (is_load) begin
      return (stage_idx >= load_ready_stage);
    end
    return (stage_idx >= 1);
  endfunction

  // Entry that will really write a register; x0 writes are architecturally void.
  function automatic logic hz_live(input hz_entry_t e);
    return e.valid & e.wr_en & (e.rd != '0);
  endfunction

endpackage : hazard_unit_pkg
`default_nettype wire

// File: rtl/hazard_unit_operand_match.sv
`default_nettype none
// ============================================================================
// Module   : hz_operand_match
// Purpose  : Priority matcher for one decode source operand against the
//            scoreboard. The youngest (lowest-index) live producer of the
//            register wins.
// Ports    : sb_i        - scoreboard entries, index 0 = X stage
//            rs_i        - source register address (scoreboard width)
//            used_i      - instruction actually reads this operand
//            sel_o       - forwarding select (0 = regfile, k = stage k-1 out)
//            not_ready_o - matching producer cannot supply the value yet
// Revision : 1.0 - initial release
// ============================================================================
module hz_operand_match
  import hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int FWD_EN           = 1,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = 2
) (
  input  hz_entry_t          sb_i [NUM_STAGES],
  input  logic [HZ_RD_W-1:0] rs_i,
  input  logic               used_i,
  output logic [SEL_W-1:0]   sel_o,
  output logic               not_ready_o
);

  // Walk from the oldest stage to the youngest so the youngest match is the
  // last assignment and therefore wins.
  always_comb begin
    sel_o       = SEL_W'(FWD_REGFILE);
    not_ready_o = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (used_i && hz_live(sb_i[i]) && (sb_i[i].rd == rs_i)) begin
        if (FWD_EN == 0) begin
          // No bypass network: any in-flight writer forces a wait.
          sel_o       = SEL_W'(FWD_REGFILE);
          not_ready_o = 1'b1;
        end else if (fwd_ready(i, sb_i[i].is_load, LOAD_READY_STAGE)) begin
          sel_o       = SEL_W'(i + 1);
          not_ready_o = 1'b0;
        end else begin
          sel_o       = SEL_W'(FWD_REGFILE);
          not_ready_o = 1'b1;
        end
      end
    end
  end

endmodule : hz_operand_match
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Decode-stage hazard unit for the in-order RV32I pipeline.
//            Tracks destinations of NUM_STAGES post-decode stages, produces
//            per-operand forwarding selects, stalls on not-ready RAW hazards
//            and multicycle X occupancy, and applies branch/jump flushes.
// Ports    : clk_i, rst_n_i             - clock, synchronous active-low reset
//            d_*_i                      - decode instruction descriptor
//            flush_i                    - redirect resolved this cycle
//            stall_o / incr_pc_o        - hold PC and D / advance PC
//            x_bubble_o                 - valid D op replaced by a bubble in X
//            mc_busy_o                  - multicycle countdown active
//            fwd1_sel_o / fwd2_sel_o    - operand sources
//            w_rd_o / w_wr_en_o         - last-stage register write
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int FWD_EN           = 1,
  parameter int LOAD_READY_STAGE = 2,
  parameter int MC_CYCLES        = 4,
  parameter int REG_ADDR_W       = 5,
  localparam int SEL_W           = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  d_valid_i,
  input  logic [REG_ADDR_W-1:0] d_rs1_i,
  input  logic                  d_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] d_rs2_i,
  input  logic                  d_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] d_rd_i,
  input  logic                  d_wr_en_i,
  input  logic                  d_is_load_i,
  input  logic                  d_is_mc_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  incr_pc_o,
  output logic                  x_bubble_o,
  output logic                  mc_busy_o,
  output logic [SEL_W-1:0]      fwd1_sel_o,
  output logic [SEL_W-1:0]      fwd2_sel_o,
  output logic [REG_ADDR_W-1:0] w_rd_o,
  output logic                  w_wr_en_o
);

  localparam int                CNT_W   = $clog2(MC_CYCLES + 1);
  localparam logic [CNT_W-1:0]  MC_LOAD = CNT_W'(MC_CYCLES - 1);

  hz_entry_t          sb_q [NUM_STAGES];
  hz_entry_t          sb_d [NUM_STAGES];
  logic [CNT_W-1:0]   mc_cnt_q;
  logic [CNT_W-1:0]   mc_cnt_d;

  hz_entry_t          d_entry;
  logic [HZ_RD_W-1:0] rs1_ext;
  logic [HZ_RD_W-1:0] rs2_ext;
  logic               rs1_not_ready;
  logic               rs2_not_ready;
  logic               mc_busy;
  logic               mc_hold;
  logic               load_d;

  assign rs1_ext = HZ_RD_W'(d_rs1_i);
  assign rs2_ext = HZ_RD_W'(d_rs2_i);

  hz_operand_match #(
    .NUM_STAGES       (NUM_STAGES),
    .FWD_EN           (FWD_EN),
    .LOAD_READY_STAGE (LOAD_READY_STAGE),
    .SEL_W            (SEL_W)
  ) u_match_rs1 (
    .sb_i        (sb_q),
    .rs_i        (rs1_ext),
    .used_i      (d_rs1_used_i),
    .sel_o       (fwd1_sel_o),
    .not_ready_o (rs1_not_ready)
  );

  hz_operand_match #(
    .NUM_STAGES       (NUM_STAGES),
    .FWD_EN           (FWD_EN),
    .LOAD_READY_STAGE (LOAD_READY_STAGE),
    .SEL_W            (SEL_W)
  ) u_match_rs2 (
    .sb_i        (sb_q),
    .rs_i        (rs2_ext),
    .used_i      (d_rs2_used_i),
    .sel_o       (fwd2_sel_o),
    .not_ready_o (rs2_not_ready)
  );

  // Control. The countdown is loaded on the edge that moves a multicycle op
  // into X, so the op occupies X for exactly MC_CYCLES cycles and mc_busy_o
  // covers the MC_CYCLES-1 cycles during which D must wait behind it.
  always_comb begin
    mc_busy    = (mc_cnt_q != '0);
    stall_o    = d_valid_i & (rs1_not_ready | rs2_not_ready | mc_busy) & ~flush_i;
    incr_pc_o  = ~stall_o;
    mc_hold    = mc_busy & ~flush_i;
    load_d     = d_valid_i & ~stall_o & ~flush_i;
    // A valid D op is dropped/held back and X receives a bubble in its place;
    // during a multicycle hold X keeps its op, so no bubble is reported.
    x_bubble_o = d_valid_i & ~load_d & ~mc_hold;
    mc_busy_o  = mc_busy;
  end

  // Decode descriptor as it would enter the scoreboard.
  always_comb begin
    d_entry         = HZ_BUBBLE;
    d_entry.valid   = d_valid_i;
    d_entry.wr_en   = d_wr_en_i;
    d_entry.is_load = d_is_load_i;
    d_entry.is_mc   = d_is_mc_i;
    d_entry.rd      = HZ_RD_W'(d_rd_i);
  end

  // Scoreboard shift. While X is held, stage 1 is fed bubbles and the older
  // stages keep draining.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      sb_d[i] = HZ_BUBBLE;
    end
    if (mc_hold) begin
      sb_d[0] = sb_q[0];
      sb_d[1] = HZ_BUBBLE;
    end else begin
      sb_d[0] = load_d ? d_entry : HZ_BUBBLE;
      sb_d[1] = sb_q[0];
    end
    for (int i = 2; i < NUM_STAGES; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  // Multicycle countdown; a flush aborts it.
  always_comb begin
    mc_cnt_d = '0;
    if (flush_i) begin
      mc_cnt_d = '0;
    end else if (mc_busy) begin
      mc_cnt_d = mc_cnt_q - CNT_W'(1);
    end else if (load_d && d_is_mc_i) begin
      mc_cnt_d = MC_LOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sb_q[i] <= HZ_BUBBLE;
      end
      mc_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        sb_q[i] <= sb_d[i];
      end
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // Register-file write port view of the last stage.
  always_comb begin
    w_wr_en_o = hz_live(sb_q[NUM_STAGES-1]);
    w_rd_o    = '0;
    if (w_wr_en_o) begin
      w_rd_o = sb_q[NUM_STAGES-1].rd[REG_ADDR_W-1:0];
    end
  end

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Purpose  : Self-checking bench for hazard_unit. Two instances share the
//            stimulus: one with forwarding (defaults) and one with FWD_EN=0.
//            Each cycle's expected outputs are queued when the stimulus is
//            driven and compared against the selected instance mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  typedef struct {
    bit       v;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       we;
    bit       ld;
    bit       mc;
  } ins_t;

  typedef struct {
    bit       dut_b;    // compare the FWD_EN=0 instance
    bit       chk_sel;  // selects are only meaningful when not stalled/flushed
    bit       stall;
    bit       bub;
    bit       busy;
    bit [1:0] f1;
    bit [1:0] f2;
    bit [4:0] wrd;
    bit       wen;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       d_valid_i;
  logic [4:0] d_rs1_i, d_rs2_i, d_rd_i;
  logic       d_rs1_used_i, d_rs2_used_i, d_wr_en_i, d_is_load_i, d_is_mc_i;
  logic       flush_i;

  logic       a_stall, a_incr, a_bub, a_busy, a_wen;
  logic [1:0] a_f1, a_f2;
  logic [4:0] a_wrd;
  logic       b_stall, b_incr, b_bub, b_busy, b_wen;
  logic [1:0] b_f1, b_f2;
  logic [4:0] b_wrd;

  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  hazard_unit u_dut_fwd (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_valid_i(d_valid_i),
    .d_rs1_i(d_rs1_i), .d_rs1_used_i(d_rs1_used_i),
    .d_rs2_i(d_rs2_i), .d_rs2_used_i(d_rs2_used_i),
    .d_rd_i(d_rd_i), .d_wr_en_i(d_wr_en_i), .d_is_load_i(d_is_load_i),
    .d_is_mc_i(d_is_mc_i), .flush_i(flush_i),
    .stall_o(a_stall), .incr_pc_o(a_incr), .x_bubble_o(a_bub),
    .mc_busy_o(a_busy), .fwd1_sel_o(a_f1), .fwd2_sel_o(a_f2),
    .w_rd_o(a_wrd), .w_wr_en_o(a_wen)
  );

  hazard_unit #(.FWD_EN(0)) u_dut_nofwd (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_valid_i(d_valid_i),
    .d_rs1_i(d_rs1_i), .d_rs1_used_i(d_rs1_used_i),
    .d_rs2_i(d_rs2_i), .d_rs2_used_i(d_rs2_used_i),
    .d_rd_i(d_rd_i), .d_wr_en_i(d_wr_en_i), .d_is_load_i(d_is_load_i),
    .d_is_mc_i(d_is_mc_i), .flush_i(flush_i),
    .stall_o(b_stall), .incr_pc_o(b_incr), .x_bubble_o(b_bub),
    .mc_busy_o(b_busy), .fwd1_sel_o(b_f1), .fwd2_sel_o(b_f2),
    .w_rd_o(b_wrd), .w_wr_en_o(b_wen)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  function automatic ins_t alu(int rd, int rs1, bit u1, int rs2, bit u2);
    ins_t i;
    i = '{v:1'b1, rs1:5'(rs1), u1:u1, rs2:5'(rs2), u2:u2, rd:5'(rd), we:1'b1, ld:1'b0, mc:1'b0};
    return i;
  endfunction

  function automatic ins_t lw(int rd, int rs1);
    ins_t i;
    i    = alu(rd, rs1, 1'b1, 0, 1'b0);
    i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t mcop(int rd, int rs1);
    ins_t i;
    i    = alu(rd, rs1, 1'b1, 0, 1'b0);
    i.mc = 1'b1;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '{v:1'b0, rs1:5'd0, u1:1'b0, rs2:5'd0, u2:1'b0, rd:5'd0, we:1'b0, ld:1'b0, mc:1'b0};
    return i;
  endfunction

  function automatic exp_t ex(bit b, bit cs, bit st, bit bu, bit busy,
                              int f1, int f2, int wrd, bit wen);
    exp_t e;
    e = '{dut_b:b, chk_sel:cs, stall:st, bub:bu, busy:busy,
          f1:2'(f1), f2:2'(f2), wrd:5'(wrd), wen:wen};
    return e;
  endfunction

  task automatic check_outputs();
    exp_t e;
    logic st, inc, bu, bsy, wen;
    logic [1:0] f1, f2;
    logic [4:0] wrd;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty step=%0d observed=0 expected=1", step_no);
      return;
    end
    e   = exp_q.pop_front();
    st  = e.dut_b ? b_stall : a_stall;
    inc = e.dut_b ? b_incr  : a_incr;
    bu  = e.dut_b ? b_bub   : a_bub;
    bsy = e.dut_b ? b_busy  : a_busy;
    f1  = e.dut_b ? b_f1    : a_f1;
    f2  = e.dut_b ? b_f2    : a_f2;
    wrd = e.dut_b ? b_wrd   : a_wrd;
    wen = e.dut_b ? b_wen   : a_wen;
    check_eq("stall",    32'(st),  32'(e.stall));
    check_eq("incr_pc",  32'(inc), 32'(!e.stall));
    check_eq("x_bubble", 32'(bu),  32'(e.bub));
    check_eq("mc_busy",  32'(bsy), 32'(e.busy));
    check_eq("w_rd",     32'(wrd), 32'(e.wrd));
    check_eq("w_wr_en",  32'(wen), 32'(e.wen));
    if (e.chk_sel) begin
      check_eq("fwd1_sel", 32'(f1), 32'(e.f1));
      check_eq("fwd2_sel", 32'(f2), 32'(e.f2));
    end
  endtask

  // Drive one decode cycle, queue its expectation, check mid-cycle, advance.
  task automatic step(input ins_t ins, input bit fl, input bit rstn, input exp_t e);
    step_no++;
    d_valid_i    = ins.v;
    d_rs1_i      = ins.rs1;
    d_rs1_used_i = ins.u1;
    d_rs2_i      = ins.rs2;
    d_rs2_used_i = ins.u2;
    d_rd_i       = ins.rd;
    d_wr_en_i    = ins.we;
    d_is_load_i  = ins.ld;
    d_is_mc_i    = ins.mc;
    flush_i      = fl;
    rst_n_i      = rstn;
    exp_q.push_back(e);
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    d_valid_i = 1'b0; d_rs1_i = '0; d_rs2_i = '0; d_rd_i = '0;
    d_rs1_used_i = 1'b0; d_rs2_used_i = 1'b0; d_wr_en_i = 1'b0;
    d_is_load_i = 1'b0; d_is_mc_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset values on both instances
    step(nop(), 0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(nop(), 0, 1, ex(1,1, 0,0,0, 0,0, 0,0));

    // ALU forwarding, back-to-back dependency, x0 handling
    step(alu(5,1,1,2,1),  0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(alu(7,3,1,4,1),  0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(alu(6,5,1,5,1),  0, 1, ex(0,1, 0,0,0, 2,2, 0,0));
    step(alu(8,6,1,0,1),  0, 1, ex(0,0, 1,1,0, 0,0, 5,1));
    step(alu(8,6,1,0,1),  0, 1, ex(0,1, 0,0,0, 2,0, 7,1));
    // Load-use: one stall, then forward from stage 2
    step(lw(9,1),         0, 1, ex(0,1, 0,0,0, 0,0, 6,1));
    step(alu(10,2,1,0,0), 0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(alu(11,9,1,0,1), 0, 1, ex(0,0, 1,1,0, 0,0, 8,1));
    step(alu(11,9,1,0,1), 0, 1, ex(0,1, 0,0,0, 3,0, 9,1));
    step(alu(0,1,1,0,0),  0, 1, ex(0,1, 0,0,0, 0,0, 10,1));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(alu(12,0,1,11,1),0, 1, ex(0,1, 0,0,0, 0,3, 11,1));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 0,0));

    // Flush coincident with a load-use hazard
    step(lw(13,1),        0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(alu(14,13,1,0,0),1, 1, ex(0,0, 0,1,0, 0,0, 12,1));
    step(alu(15,14,1,0,0),0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 13,1));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 0,0));

    // Multicycle op followed by an independent ALU op
    step(mcop(16,1),      0, 1, ex(0,1, 0,0,0, 0,0, 15,1));
    step(alu(17,2,1,0,0), 0, 1, ex(0,1, 1,0,1, 0,0, 0,0));
    step(alu(17,2,1,0,0), 0, 1, ex(0,1, 1,0,1, 0,0, 0,0));
    step(alu(17,2,1,0,0), 0, 1, ex(0,1, 1,0,1, 0,0, 0,0));
    step(alu(17,2,1,0,0), 0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 16,1));

    // Flush during countdown
    step(mcop(18,1),      0, 1, ex(0,1, 0,0,0, 0,0, 17,1));
    step(alu(19,2,1,0,0), 1, 1, ex(0,1, 0,1,1, 0,0, 0,0));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(nop(),           0, 1, ex(0,1, 0,0,0, 0,0, 18,1));

    // Reset during countdown, then during a hazard stall
    step(mcop(20,1),      0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(alu(21,2,1,0,0), 0, 0, ex(0,1, 1,0,1, 0,0, 0,0));
    step(alu(21,2,1,0,0), 0, 1, ex(0,1, 0,0,0, 0,0, 0,0));
    step(alu(22,21,1,0,0),0, 0, ex(0,0, 1,1,0, 0,0, 0,0));
    step(alu(22,21,1,0,0),0, 1, ex(0,1, 0,0,0, 0,0, 0,0));

    // FWD_EN=0 instance: drain, then a dependency stalls through X, M and W
    step(nop(),           0, 1, ex(1,1, 0,0,0, 0,0, 0,0));
    step(nop(),           0, 1, ex(1,1, 0,0,0, 0,0, 0,0));
    step(nop(),           0, 1, ex(1,1, 0,0,0, 0,0, 22,1));
    step(alu(5,1,1,2,1),  0, 1, ex(1,1, 0,0,0, 0,0, 0,0));
    step(alu(6,5,1,0,1),  0, 1, ex(1,1, 1,1,0, 0,0, 0,0));
    step(alu(6,5,1,0,1),  0, 1, ex(1,1, 1,1,0, 0,0, 0,0));
    step(alu(6,5,1,0,1),  0, 1, ex(1,1, 1,1,0, 0,0, 5,1));
    step(alu(6,5,1,0,1),  0, 1, ex(1,1, 0,0,0, 0,0, 0,0));

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_unit
`default_nettype wire
